// File: rtl/fifo_arb_pkg.sv
// Purpose: shared types and helpers for the FIFO write-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: arbiter state enum and the grant-index width helper.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Width of a producer index, clog2(n). Kept at least 1 bit so ports stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Purpose: combinational round-robin picker, first valid after 'last' (mod NumReq).
// Latency: purely combinational, zero cycles.
// Backpressure: none; it only observes the valid vector.
// Ports: valid (request vector), last (previous winner) -> any (some request
//        is valid), index (chosen producer; equals last when nothing is valid).
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NumReq = 4
) (
  input  logic [NumReq-1:0]            valid,
  input  logic [idx_width(NumReq)-1:0] last,
  output logic                         any,
  output logic [idx_width(NumReq)-1:0] index
);

  localparam int IdxW = idx_width(NumReq);

  logic [IdxW-1:0] pos;

  // Walk the ring from the farthest candidate (last itself) to the nearest
  // (last+1); a later hit overwrites an earlier one, so the nearest valid
  // producer after 'last' wins.
  always_comb begin
    any   = |valid;
    index = last;
    pos   = '0;
    for (int k = NumReq; k >= 1; k--) begin
      pos = IdxW'((int'(last) + k) % NumReq);
      if (valid[pos]) begin
        index = pos;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Purpose: round-robin arbiter sharing one sync FIFO write port among NumReq producers.
// Latency: one IDLE bubble per grant; data and write enable pass through combinationally.
// Backpressure: fifo_full drops the granted req_ready and holds grant, beat count and state.
// Ports: clk, reset_n (async, active low); req_valid/req_data/req_ready per producer;
//        fifo_full in, fifo_w_enb/fifo_din out; grant_id (current or last grant); busy (GRANT).
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NumReq   = 4,
  parameter int Width    = 16,
  parameter int MaxBurst = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NumReq-1:0]             req_valid,
  input  logic [NumReq*Width-1:0]       req_data,
  output logic [NumReq-1:0]             req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_w_enb,
  output logic [Width-1:0]              fifo_din,
  output logic [idx_width(NumReq)-1:0]  grant_id,
  output logic                          busy
);

  localparam int              IdxW     = idx_width(NumReq);
  localparam int              CntW     = (MaxBurst > 1) ? $clog2(MaxBurst) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(MaxBurst - 1);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(NumReq - 1);

  arb_state_t      state, state_nxt;
  logic [IdxW-1:0] grant_nxt;
  logic [IdxW-1:0] last_grant, last_grant_nxt;
  logic [CntW-1:0] beat_cnt, beat_cnt_nxt;
  logic            pick_any;
  logic [IdxW-1:0] pick_idx;
  logic            gnt_valid;

  rr_pick #(
    .NumReq (NumReq)
  ) u_rr_pick (
    .valid (req_valid),
    .last  (last_grant),
    .any   (pick_any),
    .index (pick_idx)
  );

  assign gnt_valid  = req_valid[grant_id];
  assign busy       = (state == GRANT);
  assign fifo_w_enb = busy && gnt_valid && !fifo_full;
  assign fifo_din   = req_data[grant_id*Width +: Width];

  // Only the granted producer sees ready, and only while the FIFO has room.
  always_comb begin
    req_ready = '0;
    if (busy) begin
      req_ready[grant_id] = !fifo_full;
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant_id;
    last_grant_nxt = last_grant;
    beat_cnt_nxt   = beat_cnt;
    case (state)
      IDLE: begin
        if (pick_any) begin
          grant_nxt = pick_idx;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (!gnt_valid) begin
          // Producer went quiet: give the port back even if the FIFO is full.
          state_nxt      = IDLE;
          beat_cnt_nxt   = '0;
          last_grant_nxt = grant_id;
        end else if (!fifo_full) begin
          if (beat_cnt == LastBeat) begin
            state_nxt      = IDLE;
            beat_cnt_nxt   = '0;
            last_grant_nxt = grant_id;
          end else begin
            beat_cnt_nxt = beat_cnt + 1'b1;
          end
        end
        // FIFO full with valid held: everything stays put.
      end
      default: state_nxt = IDLE;
    endcase
  end

  // last_grant resets to the top index so producer 0 is first after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= LastIdx;
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      grant_id   <= grant_nxt;
      last_grant <= last_grant_nxt;
      beat_cnt   <= beat_cnt_nxt;
    end
  end

endmodule
